// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM encoding and
// the reserved-opcode predicate.
package alu_pkg;

  localparam logic [3:0] OP_AND    = 4'd0;
  localparam logic [3:0] OP_OR     = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_NOR    = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd4;
  localparam logic [3:0] OP_ADD    = 4'd5;
  localparam logic [3:0] OP_SUB    = 4'd6;
  localparam logic [3:0] OP_SLT    = 4'd7;
  localparam logic [3:0] OP_SRL    = 4'd8;
  localparam logic [3:0] OP_SLL    = 4'd9;
  localparam logic [3:0] OP_SRA    = 4'd10;
  localparam logic [3:0] OP_SLTU   = 4'd11;
  localparam logic [3:0] OP_RSVD12 = 4'd12;
  localparam logic [3:0] OP_RSVD13 = 4'd13;
  localparam logic [3:0] OP_RSVD14 = 4'd14;
  localparam logic [3:0] OP_RSVD15 = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic is_reserved(input logic [3:0] op);
    return op >= OP_RSVD12;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add unsigned multiplier: one partial product per clock,
// WIDTH steps per product.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             hi_nonzero
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  // The multiplier rides in the low half of the accumulator and is consumed
  // one bit per step as the partial product shifts in from above.
  assign addend   = acc[0] ? mcand : '0;
  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_next = {sum, acc[WIDTH-1:1]};

  // The final step's result is taken straight from acc_next so the output
  // register loads on the same edge that completes the product.
  assign done       = run && (count == CW'(WIDTH - 1));
  assign product    = acc_next[WIDTH-1:0];
  assign hi_nonzero = |acc_next[2*WIDTH-1:WIDTH];

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      count <= '0;
    end else if (start) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      count <= '0;
    end else if (run) begin
      acc   <= acc_next;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle logic/arith/shift
// ops plus an iterative multiply, result and flags held until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             overflow,
  output logic             equal,
  output logic             zero,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             is_mul;
  logic             start_mul;
  logic             mul_done;
  logic             mul_hi_nz;
  logic             mul_eq;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_z;
  logic             alu_ov;

  assign accept    = in_valid && in_ready;
  assign is_mul    = (op_code == OP_MUL);
  assign start_mul = accept && is_mul;

  // ---------------- handshake FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_mul) state_nx = ST_MUL;
      ST_MUL:  if (mul_done)  state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // in_ready looks at out_ready combinationally so a result can be drained
  // and replaced on the same edge.
  always_comb begin
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    busy     = (state == ST_MUL);
  end

  // ---------------- single-cycle datapath ----------------
  assign shamt = Y[SHW-1:0];
  assign sum   = X + Y;
  assign diff  = X + ~Y + WIDTH'(1);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_z  = '0;
    alu_ov = 1'b0;
    case (op_code)
      OP_AND:  alu_z = X & Y;
      OP_OR:   alu_z = X | Y;
      OP_XOR:  alu_z = X ^ Y;
      OP_NOR:  alu_z = ~(X | Y);
      OP_ADD: begin
        alu_z  = sum;
        alu_ov = (X[MSB] == Y[MSB]) && (sum[MSB] != X[MSB]);
      end
      OP_SUB: begin
        alu_z  = diff;
        alu_ov = (X[MSB] != Y[MSB]) && (diff[MSB] != X[MSB]);
      end
      OP_SLT:  alu_z = WIDTH'($signed(X) < $signed(Y));
      OP_SRL:  alu_z = X >> shamt;
      OP_SLL:  alu_z = X << shamt;
      OP_SRA:  alu_z = $signed(X) >>> shamt;
      OP_SLTU: alu_z = WIDTH'(X < Y);
      default: alu_z = '0;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (start_mul),
    .run        (state == ST_MUL),
    .a          (X),
    .b          (Y),
    .done       (mul_done),
    .product    (mul_prod),
    .hi_nonzero (mul_hi_nz)
  );

  // ---------------- output registers ----------------
  // Accepting a MUL drains the output slot; its equal flag is parked in
  // mul_eq because X and Y are not held at the ports while it runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Z         <= '0;
      overflow  <= 1'b0;
      equal     <= 1'b0;
      zero      <= 1'b0;
      mul_eq    <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        out_valid <= 1'b0;
        mul_eq    <= (X == Y);
      end else begin
        out_valid <= 1'b1;
        Z         <= alu_z;
        overflow  <= alu_ov;
        equal     <= (X == Y);
        zero      <= (alu_z == '0) && !is_reserved(op_code);
      end
    end else if (mul_done) begin
      out_valid <= 1'b1;
      Z         <= mul_prod;
      overflow  <= mul_hi_nz;
      equal     <= mul_eq;
      zero      <= (mul_prod == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 32-bit and a 16-bit instance share operands and are
// checked every cycle against a transaction-level model plus literal pins.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] z;
    logic        ov;
    logic        zr;
    logic        eq;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x, y;
  logic [3:0]  op;
  logic        out_ready;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        ov        [2];
  logic        eq        [2];
  logic        zr        [2];
  logic        busy      [2];
  logic [31:0] z32;
  logic [15:0] z16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .X(x), .Y(y), .op_code(op), .out_valid(out_valid[0]), .out_ready(out_ready),
    .Z(z32), .overflow(ov[0]), .equal(eq[0]), .zero(zr[0]), .busy(busy[0])
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .X(x[15:0]), .Y(y[15:0]), .op_code(op), .out_valid(out_valid[1]), .out_ready(out_ready),
    .Z(z16), .overflow(ov[1]), .equal(eq[1]), .zero(zr[1]), .busy(busy[1])
  );

  function automatic int wd(input int id);
    return (id == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] zout(input int id);
    return (id == 0) ? z32 : {16'h0, z16};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic straight from the opcode definitions, in 64-bit math.
  function automatic res_t ref_op(input int w, input logic [3:0] o,
                                  input logic [31:0] xa, input logic [31:0] ya);
    longint unsigned p2, m, xv, yv, full;
    longint          sx, sy, s, lim;
    int              amt;
    res_t            r;
    p2   = 64'd1 << w;
    m    = p2 - 64'd1;
    xv   = {32'h0, xa} & m;
    yv   = {32'h0, ya} & m;
    lim  = longint'(p2 >> 1);
    sx   = (xv >= (p2 >> 1)) ? longint'(xv) - longint'(p2) : longint'(xv);
    sy   = (yv >= (p2 >> 1)) ? longint'(yv) - longint'(p2) : longint'(yv);
    amt  = int'(yv % 64'(w));
    r    = '0;
    full = 64'd0;
    case (o)
      OP_AND:  full = xv & yv;
      OP_OR:   full = xv | yv;
      OP_XOR:  full = xv ^ yv;
      OP_NOR:  full = ~(xv | yv);
      OP_MUL: begin full = xv * yv; r.ov = (full >> w) != 64'd0; end
      OP_ADD: begin s = sx + sy; full = 64'(s); r.ov = (s >= lim) || (s < -lim); end
      OP_SUB: begin s = sx - sy; full = 64'(s); r.ov = (s >= lim) || (s < -lim); end
      OP_SLT:  full = (sx < sy) ? 64'd1 : 64'd0;
      OP_SRL:  full = xv >> amt;
      OP_SLL:  full = xv << amt;
      OP_SRA:  full = 64'(sx >>> amt);
      OP_SLTU: full = (xv < yv) ? 64'd1 : 64'd0;
      default: full = 64'd0;
    endcase
    r.z  = 32'(full & m);
    r.zr = (r.z == 32'd0) && (o < 4'd12);
    r.eq = (xv == yv);
    return r;
  endfunction

  // Transaction model: one result slot per instance with the cycle it shows up.
  int   cyc = 0;
  bit   have [2] = '{1'b0, 1'b0};
  int   rdy  [2] = '{0, 0};
  res_t er   [2];

  function automatic bit m_valid(input int id);
    return have[id] && (cyc >= rdy[id]);
  endfunction

  function automatic bit m_busy(input int id);
    return have[id] && (cyc < rdy[id]);
  endfunction

  function automatic bit m_in_ready(input int id);
    return !m_busy(id) && (!m_valid(id) || out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) have[i] <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && m_in_ready(i)) begin
          have[i] <= 1'b1;
          er[i]   <= ref_op(wd(i), op, x, y);
          rdy[i]  <= cyc + 1 + ((op == OP_MUL) ? wd(i) : 0);
        end else if (m_valid(i) && out_ready) begin
          have[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("w%0d_out_valid", wd(i)), out_valid[i], m_valid(i));
        check($sformatf("w%0d_in_ready", wd(i)), in_ready[i], m_in_ready(i));
        check($sformatf("w%0d_busy", wd(i)), busy[i], m_busy(i));
        if (m_valid(i)) begin
          check($sformatf("w%0d_Z", wd(i)), zout(i), er[i].z);
          check($sformatf("w%0d_overflow", wd(i)), ov[i], er[i].ov);
          check($sformatf("w%0d_zero", wd(i)), zr[i], er[i].zr);
          check($sformatf("w%0d_equal", wd(i)), eq[i], er[i].eq);
        end
      end
    end
  end

  // Present one op to both instances and hold it until each has taken it.
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bit acc0, acc1;
    op = o; x = a; y = b;
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    for (int k = 0; k < 100 && (in_valid[0] || in_valid[1]); k++) begin
      @(negedge clk);
      acc0 = in_valid[0] && in_ready[0];
      acc1 = in_valid[1] && in_ready[1];
      @(posedge clk);
      #1;
      if (acc0) in_valid[0] = 1'b0;
      if (acc1) in_valid[1] = 1'b0;
    end
    if (in_valid[0] || in_valid[1]) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: op %0d not accepted within 100 cycles", o);
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
    end
  endtask

  task automatic pin(input string nm, input int id, input logic [31:0] ez,
                     input logic eov, input logic eeq, input logic ezr);
    check({nm, "_valid"}, out_valid[id], 1'b1);
    check({nm, "_Z"}, zout(id), ez);
    check({nm, "_overflow"}, ov[id], eov);
    check({nm, "_equal"}, eq[id], eeq);
    check({nm, "_zero"}, zr[id], ezr);
  endtask

  typedef struct packed {
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        v;
    logic        e;
    logic        zz;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV] = '{
    '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0},
    '{OP_SUB,  32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1, 1'b1},
    '{OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0},
    '{OP_NOR,  32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0},
    '{OP_MUL,  32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 1'b0, 1'b0, 1'b0},
    '{OP_SLL,  32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1'b0},
    '{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
    '{OP_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 1'b0},
    '{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0},
    '{OP_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1},
    '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
    '{OP_AND,  32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1},
    '{OP_SRA,  32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}
  };

  initial begin
    int  k, nb;
    bit  stale;
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    x = '0; y = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_out_valid", out_valid[i], 1'b0);
      check("rst_busy", busy[i], 1'b0);
      check("rst_Z", zout(i), 32'd0);
      check("rst_overflow", ov[i], 1'b0);
      check("rst_equal", eq[i], 1'b0);
      check("rst_zero", zr[i], 1'b0);
      check("rst_in_ready", in_ready[i], 1'b1);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Abort a multiply a few cycles in.
    send(OP_MUL, 32'd7, 32'd9);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("abort_busy", busy[i], 1'b0);
      check("abort_out_valid", out_valid[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) check("abort_in_ready", in_ready[i], 1'b1);
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid[0] || out_valid[1]) stale = 1'b1;
    end
    check("abort_no_stale_result", stale, 1'b0);

    // Back-to-back ADDs.
    @(posedge clk); #1;
    op = OP_ADD; x = 32'h7FFF_FFFF; y = 32'h0000_0001;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    @(negedge clk);
    check("add1_in_ready", in_ready[0], 1'b1);
    @(posedge clk); #1;
    x = 32'h0000_0005; y = 32'hFFFF_FFFB;
    @(negedge clk);
    pin("add_ovf", 0, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    check("add2_in_ready", in_ready[0], 1'b1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    @(negedge clk);
    pin("add_zero", 0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // Full-width multiply: busy through the run, result WIDTH edges after accept.
    @(posedge clk); #1;
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    k = 0; nb = 0;
    do begin
      @(negedge clk);
      k++;
      if (busy[0]) nb++;
    end while (!out_valid[0] && k < 100);
    check("mul_latency", k - 1, 32);
    check("mul_busy_cycles", nb, 32);
    pin("mul_hi", 0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Shifts and compares, pinned on the 16-bit instance.
    @(posedge clk); #1;
    send(OP_SRA, 32'h0000_8000, 32'h0000_FFF4);
    @(negedge clk);
    pin("sra16", 1, 32'h0000_F800, 1'b0, 1'b0, 1'b0);
    send(OP_SLT, 32'h0000_FFFF, 32'h0000_0001);
    @(negedge clk);
    pin("slt16", 1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send(OP_SLTU, 32'h0000_FFFF, 32'h0000_0001);
    @(negedge clk);
    pin("sltu16", 1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk); #1;
    send(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      pin("bp_hold", 0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
      check("bp_in_ready", in_ready[0], 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_OR, 32'h0000_00F0, 32'h0000_000F);
    @(negedge clk);
    pin("bp_or", 0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);

    // Reserved opcode.
    send(OP_RSVD13, 32'h0, 32'h0);
    @(negedge clk);
    pin("rsvd13_w32", 0, 32'h0, 1'b0, 1'b1, 1'b0);
    pin("rsvd13_w16", 1, 32'h0, 1'b0, 1'b1, 1'b0);

    // Directed table, pinned on the 32-bit instance.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      send(vecs[i].o, vecs[i].a, vecs[i].b);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!out_valid[0] && k < 100);
      pin($sformatf("vec%0d", i), 0, vecs[i].z, vecs[i].v, vecs[i].e, vecs[i].zz);
    end

    repeat (40) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
